mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage. It consumes the EX/MEM register fields: ALU result, store data, destination register and memory-op controls.
- Issues load/store requests to the data memory over a valid/ready request channel with a separate response channel. Aligns and sign/zero-extends load data.
- Produces the MEM/WB writeback bundle and back-pressures execute while an access is outstanding.

---
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues aligned load/store requests to data memory,
// extracts and extends load data, and produces the single-pulse MEM/WB writeback bundle.
module mem_stage #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [DataWidth-1:0]    ex_alu_res,
    input  logic [DataWidth-1:0]    ex_store_data,
    input  logic [RegAddrWidth-1:0] ex_rd,
    input  logic                    ex_rd_wr,
    input  logic                    ex_mem_rd,
    input  logic                    ex_mem_wr,
    input  logic [1:0]              ex_mem_size,
    input  logic                    ex_mem_unsigned,
    input  logic                    flush,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic [DataWidth-1:0]    dmem_addr,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic                    dmem_rsp_valid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    wb_valid,
    output logic [RegAddrWidth-1:0] wb_rd,
    output logic                    wb_rd_wr,
    output logic [DataWidth-1:0]    wb_data,
    output logic                    misaligned,
    output logic [DataWidth-1:0]    misaligned_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                  state, state_nxt;
    logic                    accept, is_mem, misalign;
    logic [3:0]              be_calc;
    logic [DataWidth-1:0]    wdata_calc;
    logic [DataWidth-1:0]    lane, load_data;
    logic                    sign_bit;

    logic [1:0]              off_q, size_q;
    logic                    unsigned_q, load_q, rd_wr_q;
    logic [RegAddrWidth-1:0] rd_q;

    assign ex_ready       = (state == IDLE);
    assign dmem_req_valid = (state == REQ);
    assign accept         = ex_valid && !flush && (state == IDLE);
    assign is_mem         = ex_mem_rd | ex_mem_wr;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        misalign   = 1'b0;
        be_calc    = 4'hF;
        wdata_calc = ex_store_data;
        case (ex_mem_size)
            2'd0: begin
                be_calc    = 4'b0001 << ex_alu_res[1:0];
                wdata_calc = {4{ex_store_data[7:0]}};
            end
            2'd1: begin
                misalign   = ex_alu_res[0];
                be_calc    = 4'b0011 << ex_alu_res[1:0];
                wdata_calc = {2{ex_store_data[15:0]}};
            end
            default: misalign = (ex_alu_res[1:0] != 2'b00);
        endcase
    end

    // Lane 0 of the shifted word holds the addressed byte/half.
    always_comb begin
        lane      = dmem_rdata >> {off_q, 3'b000};
        sign_bit  = 1'b0;
        load_data = dmem_rdata;
        case (size_q)
            2'd0: begin
                sign_bit  = lane[7] & ~unsigned_q;
                load_data = {{(DataWidth-8){sign_bit}}, lane[7:0]};
            end
            2'd1: begin
                sign_bit  = lane[15] & ~unsigned_q;
                load_data = {{(DataWidth-16){sign_bit}}, lane[15:0]};
            end
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mem && !misalign) state_nxt = REQ;
            REQ: begin
                if (flush)               state_nxt = dmem_req_ready ? DROP : IDLE;
                else if (dmem_req_ready) state_nxt = WAIT;
            end
            // A response arriving alongside flush retires the access; waiting in DROP would hang.
            WAIT: begin
                if (dmem_rsp_valid) state_nxt = IDLE;
                else if (flush)     state_nxt = DROP;
            end
            DROP: if (dmem_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_rd_wr        <= 1'b0;
            wb_data         <= '0;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
            dmem_addr       <= '0;
            dmem_we         <= 1'b0;
            dmem_be         <= 4'h0;
            dmem_wdata      <= '0;
            off_q           <= 2'b00;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            load_q          <= 1'b0;
            rd_q            <= '0;
            rd_wr_q         <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= ex_rd;
                    wb_rd_wr <= ex_rd_wr;
                    wb_data  <= ex_alu_res;
                end else if (misalign) begin
                    misaligned      <= 1'b1;
                    misaligned_addr <= ex_alu_res;
                    wb_valid        <= 1'b1;
                    wb_rd           <= ex_rd;
                    wb_rd_wr        <= 1'b0;
                    wb_data         <= ex_alu_res;
                end else begin
                    dmem_addr  <= {ex_alu_res[DataWidth-1:2], 2'b00};
                    dmem_we    <= ex_mem_wr;
                    dmem_be    <= be_calc;
                    dmem_wdata <= ex_mem_wr ? wdata_calc : '0;
                    off_q      <= ex_alu_res[1:0];
                    size_q     <= ex_mem_size;
                    unsigned_q <= ex_mem_unsigned;
                    load_q     <= ex_mem_rd;
                    rd_q       <= ex_rd;
                    rd_wr_q    <= ex_rd_wr;
                end
            end
            if (state == WAIT && dmem_rsp_valid && !flush) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_rd_wr <= load_q & rd_wr_q;
                wb_data  <= load_q ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a spec-level model supplies expected request fields,
// writeback results and misaligned reports, checked every cycle on the falling edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_res, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_wr, ex_mem_rd, ex_mem_wr, ex_mem_unsigned, flush;
    logic [1:0]  ex_mem_size;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_rd_wr, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, misaligned_addr;

    always #5 clk = ~clk;

    mem_stage #(.DataWidth(32), .RegAddrWidth(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .flush(flush),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wr(wb_rd_wr), .wb_data(wb_data),
        .misaligned(misaligned), .misaligned_addr(misaligned_addr)
    );

    typedef struct {
        logic        valid;
        logic        rd_wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } wb_exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    wb_exp_t     exp_wb = '{valid: 1'b0, rd_wr: 1'b0, rd: 5'd0, data: 32'd0, mis: 1'b0, cyc: -1};
    logic [31:0] exp_mis_addr = 32'd0;
    logic        req_exp = 1'b0;
    logic [31:0] exp_req_addr, exp_req_wdata;
    logic        exp_req_we;
    logic [3:0]  exp_req_be;
    logic        want_wb, want_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model: memory-op semantics from plain arithmetic on byte offsets.
    function automatic logic [31:0] f_ext(input int unsigned rdata, input int unsigned addr,
                                          input int size, input bit uns);
        int unsigned sh;
        int          v;
        if (size == 2) return rdata;
        sh = rdata >> (8 * (addr % 4));
        if (size == 0) begin
            v = int'(sh % 256);
            if (!uns && v >= 128) v -= 256;
        end else begin
            v = int'(sh % 65536);
            if (!uns && v >= 32768) v -= 65536;
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] f_be(input int unsigned addr, input int size);
        int          nb;
        int unsigned m;
        nb = 1 << size;
        m  = ((1 << nb) - 1) << (addr % 4);
        return 4'(m % 16);
    endfunction

    function automatic logic [31:0] f_wdata(input int unsigned data, input int size);
        int          nb;
        int unsigned r;
        nb = 1 << size;
        r  = 0;
        for (int i = 0; i < 4; i++) r |= ((data >> (8 * (i % nb))) % 256) << (8 * i);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            want_wb  = exp_wb.valid && (exp_wb.cyc == cyc);
            want_mis = want_wb && exp_wb.mis;
            check("wb_valid", 32'(wb_valid), 32'(want_wb));
            if (want_wb && wb_valid) begin
                check("wb_rd_wr", 32'(wb_rd_wr), 32'(exp_wb.rd_wr));
                if (exp_wb.rd_wr) begin
                    check("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
                    check("wb_data", wb_data, exp_wb.data);
                end
            end
            check("misaligned", 32'(misaligned), 32'(want_mis));
            check("misaligned_addr", misaligned_addr, exp_mis_addr);
            check("req_valid", 32'(dmem_req_valid), 32'(req_exp));
            if (req_exp && dmem_req_valid) begin
                check("req_addr", dmem_addr, exp_req_addr);
                check("req_we", 32'(dmem_we), 32'(exp_req_we));
                check("req_be", 32'(dmem_be), 32'(exp_req_be));
                if (exp_req_we) check("req_wdata", dmem_wdata, exp_req_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic rd_wr, input logic [4:0] rd, input logic [31:0] data,
                          input logic mis);
        exp_wb.valid = 1'b1;
        exp_wb.rd_wr = rd_wr;
        exp_wb.rd    = rd;
        exp_wb.data  = data;
        exp_wb.mis   = mis;
        exp_wb.cyc   = cyc;
    endtask

    task automatic drive_ex(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                            input logic rd_wr, input logic mrd, input logic mwr,
                            input logic [1:0] size, input logic uns);
        ex_valid        = 1'b1;
        ex_alu_res      = addr;
        ex_store_data   = data;
        ex_rd           = rd;
        ex_rd_wr        = rd_wr;
        ex_mem_rd       = mrd;
        ex_mem_wr       = mwr;
        ex_mem_size     = size;
        ex_mem_unsigned = uns;
    endtask

    task automatic arm_req(input logic [31:0] addr, input logic [31:0] data, input logic mwr,
                           input logic [1:0] size);
        req_exp       = 1'b1;
        exp_req_addr  = addr - (addr % 4);
        exp_req_we    = mwr;
        exp_req_be    = f_be(addr, int'(size));
        exp_req_wdata = f_wdata(data, int'(size));
    endtask

    // Aligned load/store: accept, stall cycles in REQ, handshake, response next cycle.
    task automatic mem_op(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                          input logic mwr, input logic [1:0] size, input logic uns,
                          input int stall, input logic [31:0] rdata,
                          input logic [31:0] lit_addr, input logic [3:0] lit_be);
        drive_ex(addr, data, rd, 1'b1, !mwr, mwr, size, uns);
        tick();
        ex_valid = 1'b0;
        arm_req(addr, data, mwr, size);
        check("lit_req_addr", dmem_addr, lit_addr);
        check("lit_req_be", 32'(dmem_be), 32'(lit_be));
        for (int i = 0; i < stall; i++) begin
            check("ex_ready_stall", 32'(ex_ready), 32'd0);
            tick();
        end
        dmem_req_ready = 1'b1;
        check("ex_ready_req", 32'(ex_ready), 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        req_exp        = 1'b0;
        check("ex_ready_wait", 32'(ex_ready), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        tick();
        dmem_rsp_valid = 1'b0;
        if (mwr) set_wb(1'b0, rd, 32'd0, 1'b0);
        else     set_wb(1'b1, rd, f_ext(rdata, addr, int'(size), uns), 1'b0);
        check("ex_ready_done", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        ex_valid       = 1'b0;
        flush          = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        tick();
        tick();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_mis_addr", misaligned_addr, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // ALU op: latency 1, no memory request.
        drive_ex(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        ex_valid = 1'b0;
        set_wb(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        check("lit_alu_wb_valid", 32'(wb_valid), 32'd1);
        check("lit_alu_wb_data", wb_data, 32'h0000_1234);
        check("lit_alu_wb_rd", 32'(wb_rd), 32'd5);
        tick();

        // Byte loads at offset 3, signed then unsigned.
        mem_op(32'h103, 32'd0, 5'd7, 1'b0, 2'd0, 1'b0, 0, 32'h80FF_0000, 32'h100, 4'b1000);
        check("lit_lb_signed", wb_data, 32'hFFFF_FF80);
        tick();
        mem_op(32'h103, 32'd0, 5'd7, 1'b0, 2'd0, 1'b1, 0, 32'h80FF_0000, 32'h100, 4'b1000);
        check("lit_lb_unsigned", wb_data, 32'h0000_0080);
        tick();

        // Half store on upper half with a 3-cycle stall.
        mem_op(32'h202, 32'hAAAA_BEEF, 5'd2, 1'b1, 2'd1, 1'b0, 3, 32'd0, 32'h200, 4'b1100);
        check("lit_sh_rd_wr", 32'(wb_rd_wr), 32'd0);
        tick();

        mem_op(32'h102, 32'd0, 5'd8, 1'b0, 2'd1, 1'b0, 0, 32'h8001_1234, 32'h100, 4'b1100);
        check("lit_lh_signed", wb_data, 32'hFFFF_8001);
        tick();
        mem_op(32'h501, 32'h0000_00A5, 5'd0, 1'b1, 2'd0, 1'b0, 0, 32'd0, 32'h500, 4'b0010);
        mem_op(32'h600, 32'd0, 5'd9, 1'b0, 2'd2, 1'b0, 1, 32'hDEAD_BEEF, 32'h600, 4'hF);
        check("lit_lw", wb_data, 32'hDEAD_BEEF);
        mem_op(32'h604, 32'h1234_5678, 5'd0, 1'b1, 2'd2, 1'b0, 1, 32'd0, 32'h604, 4'hF);
        tick();

        // Misaligned word load and misaligned half store.
        drive_ex(32'h301, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        ex_valid     = 1'b0;
        exp_mis_addr = 32'h301;
        set_wb(1'b0, 5'd9, 32'd0, 1'b1);
        check("lit_mis_flag", 32'(misaligned), 32'd1);
        check("lit_mis_addr", misaligned_addr, 32'h301);
        check("lit_mis_rd_wr", 32'(wb_rd_wr), 32'd0);
        check("lit_mis_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        drive_ex(32'h205, 32'h1111_2222, 5'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        ex_valid     = 1'b0;
        exp_mis_addr = 32'h205;
        set_wb(1'b0, 5'd3, 32'd0, 1'b1);
        tick();

        // Flush in WAIT: response swallowed, no writeback.
        drive_ex(32'h400, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        ex_valid = 1'b0;
        arm_req(32'h400, 32'd0, 1'b0, 2'd2);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        req_exp        = 1'b0;
        flush          = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("drop_ex_ready", 32'(ex_ready), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h5555_5555;
        tick();
        dmem_rsp_valid = 1'b0;
        check("drop_done_ex_ready", 32'(ex_ready), 32'd1);
        check("drop_no_wb", 32'(wb_valid), 32'd0);
        drive_ex(32'h0000_00AB, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        ex_valid = 1'b0;
        set_wb(1'b1, 5'd6, 32'h0000_00AB, 1'b0);
        check("lit_after_flush_wb", wb_data, 32'h0000_00AB);
        tick();

        // Flush in REQ before handshake, then a stray response in IDLE.
        drive_ex(32'h700, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        ex_valid = 1'b0;
        arm_req(32'h700, 32'hCAFE_F00D, 1'b1, 2'd2);
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        req_exp = 1'b0;
        check("req_flush_valid", 32'(dmem_req_valid), 32'd0);
        check("req_flush_ex_ready", 32'(ex_ready), 32'd1);
        dmem_rsp_valid = 1'b1;
        tick();
        dmem_rsp_valid = 1'b0;
        tick();

        // Flush in IDLE discards the incoming bundle.
        drive_ex(32'h0000_0042, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        check("idle_flush_no_wb", 32'(wb_valid), 32'd0);
        tick();

        // Asynchronous reset while in REQ, then a late response.
        drive_ex(32'h800, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        ex_valid = 1'b0;
        arm_req(32'h800, 32'd0, 1'b0, 2'd2);
        check("pre_rst_req_valid", 32'(dmem_req_valid), 32'd1);
        #1;
        req_exp      = 1'b0;
        exp_mis_addr = 32'd0;
        rst          = 1'b1;
        #1;
        check("async_rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("async_rst_ex_ready", 32'(ex_ready), 32'd1);
        check("async_rst_mis_addr", misaligned_addr, 32'd0);
        tick();
        rst            = 1'b0;
        dmem_rsp_valid = 1'b1;
        tick();
        dmem_rsp_valid = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
